// File: rtl/game_pkg.sv
// Shared game constants: horizontal play range, Bluetooth command bytes,
// player direction encoding and the command decoder used by player_ctrl.
package game_pkg;

  // Horizontal range shared by every stage that works in player x coordinates.
  localparam logic [11:0] X_MIN   = 12'd0;
  localparam logic [11:0] X_MAX   = 12'd600;
  localparam logic [11:0] X_RESET = 12'd300;

  // Uppercase command bytes; lowercase differs only in bit 5.
  localparam logic [7:0] CMD_BYTE_L = 8'h4C;
  localparam logic [7:0] CMD_BYTE_R = 8'h52;
  localparam logic [7:0] CMD_BYTE_S = 8'h53;
  localparam logic [7:0] CMD_BYTE_C = 8'h43;
  localparam logic [7:0] CASE_BIT   = 8'h20;

  typedef enum logic [1:0] {STOP, LEFT, RIGHT} dir_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {CMD_NONE, CMD_LEFT, CMD_RIGHT, CMD_HALT, CMD_CENTER} cmd_t;

  // Clearing bit 5 folds lowercase letters onto uppercase; only the exact
  // upper/lower pair of each letter maps onto a command byte.
  function automatic cmd_t decode_cmd(input logic [7:0] b);
    logic [7:0] u;
    u = b & ~CASE_BIT;
    case (u)
      CMD_BYTE_L: return CMD_LEFT;
      CMD_BYTE_R: return CMD_RIGHT;
      CMD_BYTE_S: return CMD_HALT;
      CMD_BYTE_C: return CMD_CENTER;
      default:    return CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/player_ctrl_uart_rx.sv
// 8N1 UART receiver, LSB first, with a 2-FF input synchronizer.
// valid pulses one cycle with data on a good stop bit; frame_err pulses one
// cycle when the stop bit reads low.
module uart_rx
  import game_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int unsigned     CW        = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]   HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0]   FULL_LAST = CW'(BAUD_DIV - 1);

  rx_state_t     state;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  always_comb rx_s = sync[1];

  // Receiver FSM: synchronizer, mid-bit sampling and byte/err pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= 2'b11;
      state     <= RX_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (!rx_s) state <= RX_START;
        end
        RX_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            state    <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt <= '0;
            shreg    <= {rx_s, shreg[7:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= RX_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt <= '0;
            state    <= RX_IDLE;
            if (rx_s) begin
              data  <= shreg;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/player_ctrl.sv
// Player paddle controller: receives Bluetooth command bytes over UART,
// tracks the movement direction and steps the player x position on a
// free-running movement tick while the game is running.
module player_ctrl
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned TICK_DIV = 2097152,
  parameter int unsigned STEP     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        ena,
  output logic [11:0] p_x,
  output logic        moving,
  output logic        cmd_err
);

  localparam int unsigned   BAUD_DIV    = CLK_HZ / BAUD;
  localparam int unsigned   TW          = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [11:0]   STEP_X      = 12'(STEP);
  localparam logic [11:0]   LEFT_LIMIT  = X_MIN + STEP_X;
  localparam logic [11:0]   RIGHT_LIMIT = X_MAX - STEP_X;

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_frame_err;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  dir_t          dir;
  cmd_t          cmd;

  uart_rx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (rx_data),
    .valid     (rx_valid),
    .frame_err (rx_frame_err)
  );

  // Decode the received byte and flag the movement tick.
  always_comb begin
    cmd  = decode_cmd(rx_data);
    tick = (tick_cnt == TICK_LAST);
  end

  // Free-running movement tick counter, independent of ena.
  always_ff @(posedge clk) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Command decode, direction state and clamped position update.
  // Clamp compares run before the add/subtract so p_x never wraps; a
  // recenter in the same cycle as a tick takes priority over the step.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_x     <= X_RESET;
      dir     <= STOP;
      moving  <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= rx_frame_err || (rx_valid && (cmd == CMD_NONE));
      if (rx_valid) begin
        case (cmd)
          CMD_LEFT: begin
            dir    <= LEFT;
            moving <= 1'b1;
          end
          CMD_RIGHT: begin
            dir    <= RIGHT;
            moving <= 1'b1;
          end
          CMD_HALT, CMD_CENTER: begin
            dir    <= STOP;
            moving <= 1'b0;
          end
          default: ;
        endcase
      end
      if (rx_valid && (cmd == CMD_CENTER)) begin
        p_x <= X_RESET;
      end else if (tick && ena) begin
        case (dir)
          LEFT:    p_x <= (p_x < LEFT_LIMIT)  ? X_MIN : p_x - STEP_X;
          RIGHT:   p_x <= (p_x > RIGHT_LIMIT) ? X_MAX : p_x + STEP_X;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: UART byte stimulus, windowed movement ticks and a
// snapshot scoreboard. Two instances run side by side, STEP=4 and STEP=8;
// the STEP=8 one overshoots both range edges so the clamps are exercised.
module tb_player_ctrl;

  localparam int unsigned BIT_CYC  = 16;
  localparam int unsigned TICK_CYC = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        ena = 1'b0;
  logic [11:0] p_x, p_x8;
  logic        moving, moving8;
  logic        cmd_err, cmd_err8;

  player_ctrl #(.CLK_HZ(160_000), .BAUD(10_000), .TICK_DIV(64), .STEP(4)) u_dut (
    .clk(clk), .rst(rst), .rx(rx), .ena(ena),
    .p_x(p_x), .moving(moving), .cmd_err(cmd_err)
  );

  player_ctrl #(.CLK_HZ(160_000), .BAUD(10_000), .TICK_DIV(64), .STEP(8)) u_dut8 (
    .clk(clk), .rst(rst), .rx(rx), .ena(ena),
    .p_x(p_x8), .moving(moving8), .cmd_err(cmd_err8)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] px;
    logic [11:0] px8;
    logic        mv;
    logic        mv8;
    logic [7:0]  errs;
    logic [7:0]  errs8;
    logic [7:0]  wide;
  } snap_t;

  snap_t exp_q[$];
  snap_t obs_q[$];
  string tag_q[$];

  int checks = 0;
  int errors = 0;
  int err_pulses = 0, err8_pulses = 0, wide_pulses = 0;
  int exp_errs = 0;
  logic err_d = 1'b0, err8_d = 1'b0;
  int m_cnt = 0;

  // Independent movement-tick phase reference.
  always @(posedge clk) begin
    if (rst) m_cnt <= 0;
    else     m_cnt <= (m_cnt == TICK_CYC - 1) ? 0 : m_cnt + 1;
  end

  // cmd_err pulse counter; any pulse longer than one cycle is counted as wide.
  always @(negedge clk) begin
    if (cmd_err === 1'b1 && err_d === 1'b0) err_pulses <= err_pulses + 1;
    if (cmd_err8 === 1'b1 && err8_d === 1'b0) err8_pulses <= err8_pulses + 1;
    if ((cmd_err === 1'b1 && err_d === 1'b1) || (cmd_err8 === 1'b1 && err8_d === 1'b1))
      wide_pulses <= wide_pulses + 1;
    err_d  <= cmd_err;
    err8_d <= cmd_err8;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1,
                           input int idle = 20);
    rx = 1'b0;
    cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(BIT_CYC);
    end
    rx = stop_bit;
    cyc(BIT_CYC);
    rx = 1'b1;
    cyc(idle);
  endtask

  // Open ena for exactly n ticks, starting mid-period.
  task automatic run_ticks(input int n);
    int guard;
    guard = 0;
    while (m_cnt != 20 && guard < 2 * TICK_CYC) begin
      cyc(1);
      guard++;
    end
    ena = 1'b1;
    cyc(n * TICK_CYC);
    ena = 1'b0;
  endtask

  task automatic snap(input string tag, input int px, input int px8, input logic mv);
    exp_q.push_back('{px: 12'(px), px8: 12'(px8), mv: mv, mv8: mv,
                      errs: 8'(exp_errs), errs8: 8'(exp_errs), wide: 8'd0});
    obs_q.push_back('{px: p_x, px8: p_x8, mv: moving, mv8: moving8,
                      errs: 8'(err_pulses), errs8: 8'(err8_pulses), wide: 8'(wide_pulses)});
    tag_q.push_back(tag);
  endtask

  task automatic test_reset;
    snap_t e, o; string t;
    rst = 1'b1; rx = 1'b1; ena = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    snap("reset", 300, 300, 1'b0);
    if (cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_cmd_err: got %b want 0", cmd_err);
    end
    checks++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got px=%0d px8=%0d mv=%b/%b err=%0d/%0d wide=%0d want px=%0d px8=%0d mv=%b/%b err=%0d/%0d wide=%0d",
                 t, o.px, o.px8, o.mv, o.mv8, o.errs, o.errs8, o.wide,
                 e.px, e.px8, e.mv, e.mv8, e.errs, e.errs8, e.wide);
      end
    end
  endtask

  task automatic test_move_right;
    snap_t e, o; string t;
    send_byte(8'h52);
    snap("right_decoded_ena_low", 300, 300, 1'b1);
    run_ticks(10);
    snap("right_10_ticks", 340, 380, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got px=%0d px8=%0d mv=%b/%b err=%0d/%0d wide=%0d want px=%0d px8=%0d mv=%b/%b err=%0d/%0d wide=%0d",
                 t, o.px, o.px8, o.mv, o.mv8, o.errs, o.errs8, o.wide,
                 e.px, e.px8, e.mv, e.mv8, e.errs, e.errs8, e.wide);
      end
    end
  endtask

  task automatic test_clamp;
    snap_t e, o; string t;
    run_ticks(64);
    snap("right_to_596", 596, 600, 1'b1);
    run_ticks(1);
    snap("right_clamp_600", 600, 600, 1'b1);
    run_ticks(3);
    snap("right_hold_600", 600, 600, 1'b1);
    send_byte(8'h43);
    snap("center_ena_low", 300, 300, 1'b0);
    send_byte(8'h4C);
    snap("left_decoded", 300, 300, 1'b1);
    run_ticks(37);
    snap("left_37", 152, 4, 1'b1);
    run_ticks(1);
    snap("left_clamp_0_step8", 148, 0, 1'b1);
    run_ticks(37);
    snap("left_to_0", 0, 0, 1'b1);
    run_ticks(2);
    snap("left_hold_0", 0, 0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got px=%0d px8=%0d mv=%b/%b err=%0d/%0d wide=%0d want px=%0d px8=%0d mv=%b/%b err=%0d/%0d wide=%0d",
                 t, o.px, o.px8, o.mv, o.mv8, o.errs, o.errs8, o.wide,
                 e.px, e.px8, e.mv, e.mv8, e.errs, e.errs8, e.wide);
      end
    end
  endtask

  task automatic test_bad_cmd;
    snap_t e, o; string t;
    send_byte(8'h52);
    run_ticks(2);
    snap("right_from_0", 8, 16, 1'b1);
    send_byte(8'h41);
    exp_errs++;
    snap("unknown_0x41", 8, 16, 1'b1);
    run_ticks(1);
    snap("dir_kept_after_0x41", 12, 24, 1'b1);
    send_byte(8'h73);
    snap("lower_s", 12, 24, 1'b0);
    run_ticks(1);
    snap("stop_holds", 12, 24, 1'b0);
    send_byte(8'h6C);
    run_ticks(1);
    snap("lower_l", 8, 16, 1'b1);
    send_byte(8'h72);
    run_ticks(1);
    snap("lower_r", 12, 24, 1'b1);
    send_byte(8'h63);
    snap("lower_c", 300, 300, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got px=%0d px8=%0d mv=%b/%b err=%0d/%0d wide=%0d want px=%0d px8=%0d mv=%b/%b err=%0d/%0d wide=%0d",
                 t, o.px, o.px8, o.mv, o.mv8, o.errs, o.errs8, o.wide,
                 e.px, e.px8, e.mv, e.mv8, e.errs, e.errs8, e.wide);
      end
    end
  endtask

  task automatic test_frame_err;
    snap_t e, o; string t;
    send_byte(8'h4C, 1'b0, 30);
    exp_errs++;
    snap("bad_stop_bit", 300, 300, 1'b0);
    rx = 1'b0;
    cyc(1);
    rx = 1'b1;
    cyc(40);
    snap("idle_glitch", 300, 300, 1'b0);
    send_byte(8'h52);
    snap("rx_after_glitch", 300, 300, 1'b1);
    send_byte(8'h53);
    snap("upper_s", 300, 300, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got px=%0d px8=%0d mv=%b/%b err=%0d/%0d wide=%0d want px=%0d px8=%0d mv=%b/%b err=%0d/%0d wide=%0d",
                 t, o.px, o.px8, o.mv, o.mv8, o.errs, o.errs8, o.wide,
                 e.px, e.px8, e.mv, e.mv8, e.errs, e.errs8, e.wide);
      end
    end
  endtask

  task automatic test_ena_low;
    snap_t e, o; string t;
    send_byte(8'h4C);
    cyc(5 * TICK_CYC);
    snap("left_ena_low_5_ticks", 300, 300, 1'b1);
    send_byte(8'h43);
    snap("center_stops", 300, 300, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got px=%0d px8=%0d mv=%b/%b err=%0d/%0d wide=%0d want px=%0d px8=%0d mv=%b/%b err=%0d/%0d wide=%0d",
                 t, o.px, o.px8, o.mv, o.mv8, o.errs, o.errs8, o.wide,
                 e.px, e.px8, e.mv, e.mv8, e.errs, e.errs8, e.wide);
      end
    end
  endtask

  task automatic test_back_to_back;
    snap_t e, o; string t;
    send_byte(8'h52, 1'b1, 0);
    send_byte(8'h4C);
    run_ticks(1);
    snap("b2b_r_then_l", 296, 292, 1'b1);
    send_byte(8'h53, 1'b1, 0);
    send_byte(8'h41);
    exp_errs++;
    snap("b2b_s_then_bad", 296, 292, 1'b0);
    send_byte(8'h43);
    snap("b2b_recenter", 300, 300, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got px=%0d px8=%0d mv=%b/%b err=%0d/%0d wide=%0d want px=%0d px8=%0d mv=%b/%b err=%0d/%0d wide=%0d",
                 t, o.px, o.px8, o.mv, o.mv8, o.errs, o.errs8, o.wide,
                 e.px, e.px8, e.mv, e.mv8, e.errs, e.errs8, e.wide);
      end
    end
  endtask

  // Sweep the 'C' frame start across the tick phase so that one attempt lands
  // its decode exactly on a tick while moving right.
  task automatic test_center_on_tick;
    snap_t e, o; string t;
    int guard;
    for (int v = 30; v <= 42; v++) begin
      send_byte(8'h52);
      ena = 1'b1;
      guard = 0;
      while (m_cnt != v && guard < 2 * TICK_CYC) begin
        cyc(1);
        guard++;
      end
      send_byte(8'h43);
      ena = 1'b0;
      snap($sformatf("center_on_tick_phase%0d", v), 300, 300, 1'b0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got px=%0d px8=%0d mv=%b/%b err=%0d/%0d wide=%0d want px=%0d px8=%0d mv=%b/%b err=%0d/%0d wide=%0d",
                 t, o.px, o.px8, o.mv, o.mv8, o.errs, o.errs8, o.wide,
                 e.px, e.px8, e.mv, e.mv8, e.errs, e.errs8, e.wide);
      end
    end
  endtask

  task automatic test_reset_midframe;
    snap_t e, o; string t;
    logic [7:0] r_byte;
    r_byte = 8'h52;
    send_byte(8'h52);
    run_ticks(2);
    snap("pre_reset_move", 308, 316, 1'b1);
    rx = 1'b0;
    cyc(BIT_CYC);
    for (int i = 0; i < 3; i++) begin
      rx = r_byte[i];
      cyc(BIT_CYC);
    end
    rst = 1'b1;
    rx  = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(40);
    snap("reset_midframe", 300, 300, 1'b0);
    send_byte(8'h4C);
    snap("left_after_reset", 300, 300, 1'b1);
    run_ticks(1);
    snap("left_step_after_reset", 296, 292, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got px=%0d px8=%0d mv=%b/%b err=%0d/%0d wide=%0d want px=%0d px8=%0d mv=%b/%b err=%0d/%0d wide=%0d",
                 t, o.px, o.px8, o.mv, o.mv8, o.errs, o.errs8, o.wide,
                 e.px, e.px8, e.mv, e.mv8, e.errs, e.errs8, e.wide);
      end
    end
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_clamp();
    test_bad_cmd();
    test_frame_err();
    test_ena_low();
    test_back_to_back();
    test_center_on_tick();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
